// File: rtl/fp_arb_pkg.sv
// Shared types and IEEE-754 single-precision field constants for the FP adder arbiter.
package fp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int FP_SIGN    = 31;
  localparam int FP_EXP_MSB = 30;
  localparam int FP_EXP_LSB = 23;
  localparam int FP_MAN_W   = 23;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  // True when exponent and mantissa are both zero (sign excluded).
  function automatic logic fp_mag_is_zero(input logic [FP_EXP_MSB:0] mag);
    return (mag[FP_EXP_MSB:FP_EXP_LSB] == '0) && (mag[FP_MAN_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Client and shared-adder signal bundle for fp_add_arbiter.
interface fp_add_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [31:0]        rsp_result;
  logic [31:0]        add_a;
  logic [31:0]        add_b;
  logic [31:0]        add_result;
  logic               busy;
  logic [GW-1:0]      grant_id;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, add_result,
    output req_ready, rsp_valid, rsp_result, add_a, add_b, busy, grant_id
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, add_result,
    input  req_ready, rsp_valid, rsp_result, add_a, add_b, busy, grant_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [GW-1:0]   idx,
  output logic            any
);

  logic [GW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one external combinational FP adder among NREQ clients.
// Optional FP_ARB_ZERO_BYPASS_EN: route zero-magnitude operands around the adder.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic            clk,
  input logic            rst,
  fp_add_arbiter_if.slave bus
);

  localparam int GW = $clog2(NREQ);

  state_t          state;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   grant_id_r;
  logic [GW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [NREQ-1:0] rsp_valid_r;
  logic            win_any;
  logic            busy_r;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic [31:0]     a_p0;
  logic [31:0]     b_p0;
  logic [31:0]     result_p1;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (win_onehot),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_onehot[i]) begin
        sel_a = bus.req_a[32*i +: 32];
        sel_b = bus.req_b[32*i +: 32];
      end
    end
  end

`ifdef FP_ARB_ZERO_BYPASS_EN
  // The shared adder always inserts the hidden 1, so true zeros must skip it.
  function automatic logic [31:0] zero_bypass(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] sum);
    logic a_z;
    logic b_z;
    a_z = fp_mag_is_zero(a[FP_EXP_MSB:0]);
    b_z = fp_mag_is_zero(b[FP_EXP_MSB:0]);
    if (a_z && b_z)
      return FP_POS_ZERO | {a[FP_SIGN] & b[FP_SIGN], 31'b0};
    else if (a_z)
      return b;
    else if (b_z)
      return a;
    else
      return sum;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= GW'(NREQ - 1);
      grant_id_r  <= '0;
      a_p0        <= '0;
      b_p0        <= '0;
      result_p1   <= '0;
      rsp_valid_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        // p0: winner's operands launched to the shared adder
        IDLE: begin
          if (win_any) begin
            a_p0       <= sel_a;
            b_p0       <= sel_b;
            grant_id_r <= win_idx;
            ptr        <= win_idx;
            busy_r     <= 1'b1;
            state      <= EXEC;
          end
        end
        // p1: adder has settled for one cycle, capture its sum
        EXEC: begin
`ifdef FP_ARB_ZERO_BYPASS_EN
          result_p1 <= zero_bypass(a_p0, b_p0, bus.add_result);
`else
          result_p1 <= bus.add_result;
`endif
          rsp_valid_r <= NREQ'(1) << grant_id_r;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[grant_id_r]) begin
            rsp_valid_r <= '0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // req_ready is combinational from the arbiter; masked while reset is held.
  assign bus.req_ready  = (state == IDLE && !rst) ? win_onehot : '0;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = result_p1;
  assign bus.add_a      = a_p0;
  assign bus.add_b      = b_p0;
  assign bus.busy       = busy_r;
  assign bus.grant_id   = grant_id_r;

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

- Shares one combinational 32-bit floating-point adder (`sumador_fp`, instantiated outside this block) among NREQ requesters.
- Accepts requests by per-requester valid/ready handshake, chosen round-robin, and launches one operation at a time.
- Captures the adder output and returns it to the owning requester.
- Sits between the client units and the shared FP adder instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- GW, $clog2(NREQ), grant index width (derived, not overridden)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_a  in  NREQ*32  operand A per requester, slice i = [32*i+31:32*i]
- req_b  in  NREQ*32  operand B per requester, same slicing
- rsp_valid  out  NREQ  result valid for owning requester (one-hot or zero)
- rsp_ready  in  NREQ  requester takes result
- rsp_result  out  32  shared result bus, meaningful only where rsp_valid set
- add_a  out  32  operand A to external adder (registered)
- add_b  out  32  operand B to external adder (registered)
- add_result  in  32  combinational sum from external adder
- busy  out  1  high in any state but IDLE
- grant_id  out  GW  index of current owner, held from accept to response completion

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - If any req_valid, pick the winner: first set bit searching from ptr+1 upward, wrapping modulo NREQ.
  - Assert req_ready[winner] combinationally in that same cycle.
  - On the clock edge: latch req_a/req_b of the winner into add_a/add_b, latch winner into grant_id, set ptr=winner, go to EXEC.
  - No request: stay in IDLE; ptr unchanged.
- EXEC (exactly 1 cycle): the adder settles; on the edge, capture add_result into the result register and go to RESP.
- RESP
  - rsp_valid[grant_id]=1; rsp_result=result register.
  - On rsp_ready[grant_id]: go to IDLE.
  - Otherwise hold; result and operands stay stable.
  - rsp_ready bits of non-owners are ignored.
- Only one operation is in flight. req_ready is zero outside IDLE.
- A requester may keep req_valid high while its own response is pending. It is not re-granted until the FSM returns to IDLE.
- Fairness: a continuously requesting client waits at most NREQ-1 other operations.
- Operands are passed bit-exact. The block does not alter sign, exponent or mantissa.

## Timing
- Reset values: state=IDLE, ptr=NREQ-1 (requester 0 wins the first tie), grant_id=0, add_a=add_b=0, result=0, req_ready=0, rsp_valid=0, busy=0.
- Accept in cycle N → rsp_valid high from cycle N+2.
- Minimum issue interval is 3 cycles: accept, EXEC, RESP with rsp_ready=1, back to IDLE, next accept at N+3.
- The earliest a new accept can occur is the first cycle IDLE is re-entered.
- Simultaneous req_valid from all requesters: grants rotate strictly 0,1,2,3,0… from reset.
- Reset asserted mid-operation: all state clears immediately. The in-flight result is discarded and no rsp_valid is issued afterward.
- req_valid dropping in RESP has no effect. rsp_ready arriving in IDLE or EXEC is ignored.

## Configuration
- FP_ARB_ZERO_BYPASS_EN defined:
  - In EXEC, if add_a[30:0]==0 the captured result is add_b; else if add_b[30:0]==0 it is add_a.
  - If both are zero, the result is {add_a[31]&add_b[31], 31'b0}.
  - Bypass exists because the shared adder always inserts the hidden 1.
  - Latency is unchanged.
- Macro undefined: the result is always add_result.

## Structure
- Shared package fp_arb_pkg holds:
  - state enum (IDLE, EXEC, RESP);
  - FP field constants: FP_SIGN=31, FP_EXP_MSB=30, FP_EXP_LSB=23, FP_MAN_W=23;
  - FP_POS_ZERO=32'h0000_0000.
- One sub-module: rr_arbiter.
  - Inputs: request vector and ptr, parameterised by NREQ.
  - Output: one-hot grant and encoded index.
  - Purely combinational.
- Pointer register, FSM and datapath registers live in fp_add_arbiter.

## Test plan
- Single request: req 0 sends A=32'h3F80_0000, B=32'h3F80_0000.
  - req_ready[0] is high in cycle N.
  - rsp_valid[0] is high at N+2 with rsp_result=32'h4000_0000.
- All four requesters are held valid with rsp_ready tied high.
  - Grant order is 0,1,2,3,0.
  - Successive accepts are exactly 3 cycles apart.
- Backpressure: rsp_ready[1] held low for 5 cycles.
  - rsp_valid[1], rsp_result and grant_id stay stable.
  - req_ready stays 0 throughout.
  - The next grant occurs in the first IDLE cycle after the handshake.
- Reset pulse during EXEC: all outputs return to their reset values asynchronously.
  - No rsp_valid follows.
  - After release, requester 0 wins a 0/2 tie.
- With FP_ARB_ZERO_BYPASS_EN: A=32'h0000_0000, B=32'h4040_0000 → rsp_result=32'h4040_0000.
  - Also A=32'h8000_0000, B=32'h8000_0000 → rsp_result=32'h8000_0000.
  - Without the macro, the result equals the adder's raw add_result.
